// File: rtl/inst_prefetch_reg.sv
// Instruction prefetch register: DEPTH-entry byte queue feeding a current-instruction register.
// Latency: queue head -> inst_out 1 cycle; bypass load into an idle empty register 1 cycle.
// Backpressure: none to the bus; loads while full and holding a valid instruction are dropped and flagged in overflow.
//
// Ports:
//   clk, rst_n        - rising-edge clock, asynchronous active-low reset
//   data_in, ld_inst  - instruction byte from the data bus and its load strobe
//   advance, flush    - sequencer consume strobe and taken-branch discard
//   inst_out/_valid   - current instruction and its valid flag
//   full, count       - queue occupancy (excludes the current register)
//   overflow          - sticky dropped-load flag, cleared by reset or flush
//   led_ld            - combinational copy of ld_inst for the front panel
//   inst_class        - decoded class of inst_out (0 unless INST_CLASS_DECODE_EN is defined)
//
// Build option: define INST_CLASS_DECODE_EN to synthesise the instruction class decoder.

module inst_prefetch_reg #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ld_inst,
   input  logic             advance,
   input  logic             flush,
   output logic [WIDTH-1:0] inst_out,
   output logic             inst_valid,
   output logic             full,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             led_ld,
   output logic [2:0]       inst_class
);

   localparam int PTR_W = $clog2(DEPTH);

   // Queue storage needs no reset: occupancy and pointers decide what is live.
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             full_q,   full_d;
   logic             valid_q,  valid_d;
   logic             ovf_q,    ovf_d;
   logic [WIDTH-1:0] inst_q,   inst_d;

   logic push;
   logic slot_free;
   logic q_empty;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      valid_d   = valid_q;
      ovf_d     = ovf_q;
      inst_d    = inst_q;
      push      = 1'b0;
      q_empty   = (count_q == '0);
      // The current register can take a new word if it is idle or being consumed.
      slot_free = !valid_q || advance;

      if (flush) begin
         // Taken branch: everything prefetched is stale; inst_out keeps its last value.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         valid_d  = 1'b0;
         ovf_d    = 1'b0;
      end else if (slot_free) begin
         if (!q_empty) begin
            // Head moves into the current register; a simultaneous load
            // always has room because a slot is being freed.
            inst_d   = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            push     = ld_inst;
            if (!ld_inst) begin
               count_d = count_q - CNT_W'(1);
            end
         end else if (ld_inst) begin
            // Empty queue: bypass straight into the current register.
            inst_d  = data_in;
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end else if (ld_inst) begin
         if (!full_q) begin
            push    = 1'b1;
            count_d = count_q + CNT_W'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      full_d = (count_d == CNT_W'(DEPTH));
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         inst_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         inst_q   <= inst_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   // ------------------------------------------------------------------
   // Instruction class decode (registered with inst_out)
   // ------------------------------------------------------------------
`ifdef INST_CLASS_DECODE_EN
   logic [2:0] class_q, class_d;

   function automatic logic [2:0] decode_class(input logic [7:0] op);
      logic [2:0] c;
      c = 3'd7;
      casez (op)
         8'b00??????: c = 3'd0;  // MOV8
         8'b01??????: c = 3'd1;  // SETAB
         8'b1000????: c = 3'd2;  // ALU
         8'b1001????: c = 3'd3;  // LOAD/STORE
         8'b1010????: c = 3'd4;  // MOV16/INC
         8'b11??????: c = 3'd5;  // GOTO/branch
         default:     c = 3'd7;  // reserved
      endcase
      return c;
   endfunction

   always_comb begin
      class_d = '0;
      if (valid_d) begin
         class_d = decode_class(inst_d[WIDTH-1 -: 8]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         class_q <= '0;
      end else begin
         class_q <= class_d;
      end
   end

   assign inst_class = class_q;
`else
   assign inst_class = 3'd0;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign inst_out   = inst_q;
   assign inst_valid = valid_q;
   assign full       = full_q;
   assign count      = count_q;
   assign overflow   = ovf_q;
   assign led_ld     = ld_inst;

endmodule
